// File: rtl/timer_pkg.sv
// Shared time-field widths, limits, state encoding and field arithmetic for the
// countdown timer and the stopwatch that drive the same seven-segment path.
package timer_pkg;

    localparam int HMS_W  = 7;
    localparam int CSEC_W = 8;

    localparam logic [HMS_W-1:0]  HOUR_MAX = 7'd23;
    localparam logic [HMS_W-1:0]  MIN_MAX  = 7'd59;
    localparam logic [HMS_W-1:0]  SEC_MAX  = 7'd59;
    localparam logic [CSEC_W-1:0] CSEC_MAX = 8'd99;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    typedef struct packed {
        logic [HMS_W-1:0]  hour;
        logic [HMS_W-1:0]  minute;
        logic [HMS_W-1:0]  second;
        logic [CSEC_W-1:0] csec;
    } hms_t;

    localparam hms_t LAST_CSEC = '{hour: 7'd0, minute: 7'd0, second: 7'd0, csec: 8'd1};

    function automatic hms_t clamp_time(input hms_t t);
        hms_t c;
        c.hour   = (t.hour   > HOUR_MAX) ? HOUR_MAX : t.hour;
        c.minute = (t.minute > MIN_MAX)  ? MIN_MAX  : t.minute;
        c.second = (t.second > SEC_MAX)  ? SEC_MAX  : t.second;
        c.csec   = (t.csec   > CSEC_MAX) ? CSEC_MAX : t.csec;
        return c;
    endfunction

    // Ripple-borrow decrement; the all-zero value is never passed in.
    function automatic hms_t decrement(input hms_t t);
        hms_t d;
        d = t;
        if (t.csec != '0) begin
            d.csec = t.csec - CSEC_W'(1);
        end else begin
            d.csec = CSEC_MAX;
            if (t.second != '0) begin
                d.second = t.second - HMS_W'(1);
            end else begin
                d.second = SEC_MAX;
                if (t.minute != '0) begin
                    d.minute = t.minute - HMS_W'(1);
                end else begin
                    d.minute = MIN_MAX;
                    d.hour   = t.hour - HMS_W'(1);
                end
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Clock-enable generator: one-clock tick every CLK_HZ/TICK_HZ enabled clocks.
// The count holds while disabled, so tick phase survives a pause.
module tick_divider #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS.cc preset countdown: decrements at TICK_HZ while running, stops at
// zero with a held expired flag and a single-clock alarm pulse.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              run,
    input  logic [HMS_W-1:0]  set_hour,
    input  logic [HMS_W-1:0]  set_minute,
    input  logic [HMS_W-1:0]  set_second,
    input  logic [CSEC_W-1:0] set_csec,
    output logic [HMS_W-1:0]  hour,
    output logic [HMS_W-1:0]  minute,
    output logic [HMS_W-1:0]  second,
    output logic [CSEC_W-1:0] c_sec,
    output logic              running,
    output logic              expired,
    output logic              alarm
);

    state_t state, state_next;
    hms_t   value, value_next;
    logic   alarm_next;
    logic   count_enable;
    logic   tick;

    assign count_enable = (state == RUN);

    tick_divider #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick_divider (
        .clock (clock),
        .reset (reset),
        .enable(count_enable),
        .clear (load),
        .tick  (tick)
    );

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        value_next = value;
        alarm_next = 1'b0;
        if (load) begin
            // Load wins over a coincident tick, which is simply dropped.
            value_next = clamp_time('{hour: set_hour, minute: set_minute,
                                      second: set_second, csec: set_csec});
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (run && (value != '0)) state_next = RUN;
                end
                RUN: begin
                    if (tick && (value == LAST_CSEC)) begin
                        value_next = '0;
                        alarm_next = 1'b1;
                        state_next = EXPIRED;
                    end else begin
                        if (tick) value_next = decrement(value);
                        if (!run) state_next = PAUSE;
                    end
                end
                PAUSE: begin
                    if (run) state_next = RUN;
                end
                EXPIRED: begin
                    state_next = EXPIRED;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            value <= '0;
            alarm <= 1'b0;
        end else begin
            state <= state_next;
            value <= value_next;
            alarm <= alarm_next;
        end
    end

    assign hour    = value.hour;
    assign minute  = value.minute;
    assign second  = value.second;
    assign c_sec   = value.csec;
    assign running = (state == RUN);
    assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: a centisecond-count reference model queues the expected
// outputs per clock; an independent monitor pops and compares on each falling edge.
module tb_countdown_timer;

    localparam int DIV = 10;

    logic       clock;
    logic       reset;
    logic       load;
    logic       run;
    logic [6:0] set_hour, set_minute, set_second;
    logic [7:0] set_csec;
    logic [6:0] hour, minute, second;
    logic [7:0] c_sec;
    logic       running, expired, alarm;

    countdown_timer #(
        .CLK_HZ (1000),
        .TICK_HZ(100)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .run       (run),
        .set_hour  (set_hour),
        .set_minute(set_minute),
        .set_second(set_second),
        .set_csec  (set_csec),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .c_sec     (c_sec),
        .running   (running),
        .expired   (expired),
        .alarm     (alarm)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_alarm  = 0;
    bit mon_en   = 1'b0;
    logic [31:0] exp_q[$];

    // Reference model: the time is a single count of centiseconds.
    int m_val;
    int m_phase;
    bit m_running;
    bit m_expired;
    bit m_alarm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] dut_snap();
        return {hour, minute, second, c_sec, running, expired, alarm};
    endfunction

    function automatic logic [31:0] pack_time(input int h, input int m, input int s, input int c,
                                              input bit r, input bit e, input bit a);
        return {7'(h), 7'(m), 7'(s), 8'(c), r, e, a};
    endfunction

    function automatic logic [31:0] model_snap();
        return pack_time(m_val / 360000, (m_val / 6000) % 60, (m_val / 100) % 60, m_val % 100,
                         m_running, m_expired, m_alarm);
    endfunction

    function automatic void model_reset();
        m_val = 0; m_phase = 0; m_running = 0; m_expired = 0; m_alarm = 0;
    endfunction

    function automatic void model_edge(input bit ld, input bit rn, input int h, input int m,
                                       input int s, input int c);
        m_alarm = 0;
        if (ld) begin
            if (h > 23) h = 23;
            if (m > 59) m = 59;
            if (s > 59) s = 59;
            if (c > 99) c = 99;
            m_val = ((h * 60 + m) * 60 + s) * 100 + c;
            m_phase = 0; m_running = 0; m_expired = 0;
        end else if (!m_expired) begin
            if (m_running) begin
                if (m_phase == DIV - 1) begin
                    m_phase = 0;
                    if (m_val == 1) begin
                        m_val = 0; m_alarm = 1; m_running = 0; m_expired = 1;
                    end else begin
                        m_val = m_val - 1;
                        m_running = rn;
                    end
                end else begin
                    m_phase = m_phase + 1;
                    m_running = rn;
                end
            end else begin
                m_running = rn && (m_val != 0);
            end
        end
    endfunction

    task automatic step(input bit ld, input bit rn, input int h, input int m, input int s, input int c);
        @(negedge clock);
        load = ld; run = rn;
        set_hour = 7'(h); set_minute = 7'(m); set_second = 7'(s); set_csec = 8'(c);
        @(posedge clock);
        model_edge(ld, rn, h, m, s, c);
        exp_q.push_back(model_snap());
    endtask

    task automatic run_for(input int n, input bit rn);
        repeat (n) step(1'b0, rn, 0, 0, 0, 0);
    endtask

    // Called right after a step: asserts reset between clock edges.
    task automatic do_reset();
        #3;
        mon_en = 1'b0;
        exp_q.delete();
        reset = 1'b1;
        #1;
        check("async_reset", dut_snap(), 32'h0);
        model_reset();
        repeat (3) @(negedge clock);
        load = 1'b0; run = 1'b0;
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    always @(negedge clock) begin
        if (alarm === 1'b1) n_alarm++;
        if (mon_en && exp_q.size() > 0) check("cycle", dut_snap(), exp_q.pop_front());
    end

    initial begin
        int base;
        bit r;
        load = 0; run = 0; reset = 0;
        set_hour = 0; set_minute = 0; set_second = 0; set_csec = 0;
        model_reset();
        #2 reset = 1'b1;
        #1 check("reset_state", dut_snap(), 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        mon_en = 1'b1;

        // Reset mid-count; counting must not resume without a new load.
        step(1, 0, 0, 0, 5, 50);
        run_for(37, 1);
        do_reset();
        run_for(30, 1);
        #1 check("no_resume_after_reset", dut_snap(), 32'h0);

        // Full countdown to expiry, then run toggles have no effect.
        step(1, 1, 0, 0, 1, 5);
        base = n_alarm;
        run_for(1060, 1);
        #1 check("expired_state", dut_snap(), pack_time(0, 0, 0, 0, 0, 1, 0));
        check("alarm_pulses", 32'(n_alarm - base), 32'd1);
        for (int i = 0; i < 40; i++) step(0, 1'($urandom), 0, 0, 0, 0);
        #1 check("expired_sticky", dut_snap(), pack_time(0, 0, 0, 0, 0, 1, 0));

        // Multi-field borrows.
        step(1, 1, 1, 0, 0, 0);
        run_for(11, 1);
        #1 check("borrow_hour", dut_snap(), pack_time(0, 59, 59, 99, 1, 0, 0));
        step(1, 1, 0, 1, 0, 0);
        run_for(11, 1);
        #1 check("borrow_minute", dut_snap(), pack_time(0, 0, 59, 99, 1, 0, 0));

        // Pause preserves value and tick phase.
        step(1, 0, 0, 0, 0, 50);
        run_for(24, 1);
        run_for(50, 0);
        #1 check("paused_hold", dut_snap(), pack_time(0, 0, 0, 48, 0, 0, 0));
        run_for(10, 1);
        #1 check("resumed_tick", dut_snap(), pack_time(0, 0, 0, 47, 1, 0, 0));

        // Clamping and the zero-value run request.
        step(1, 0, 30, 75, 80, 150);
        #1 check("clamp", dut_snap(), pack_time(23, 59, 59, 99, 0, 0, 0));
        base = n_alarm;
        step(1, 1, 0, 0, 0, 0);
        run_for(20, 1);
        #1 check("zero_stays_idle", dut_snap(), 32'h0);
        check("zero_no_alarm", 32'(n_alarm - base), 32'd0);

        // Load on the same edge as a tick discards the tick and clears the divider.
        step(1, 0, 0, 0, 3, 21);
        run_for(20, 1);
        step(1, 1, 0, 0, 10, 0);
        #1 check("load_over_tick", dut_snap(), pack_time(0, 0, 10, 0, 0, 0, 0));
        run_for(10, 1);
        #1 check("no_early_tick", dut_snap(), pack_time(0, 0, 10, 0, 1, 0, 0));
        run_for(1, 1);
        #1 check("tick_after_reentry", dut_snap(), pack_time(0, 0, 9, 99, 1, 0, 0));

        // Randomized traffic: loads, run toggles, one asynchronous reset.
        r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit ld;
            int h, m, s, c;
            ld = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 24) == 0) r = !r;
            if ($urandom_range(0, 1) == 1) begin
                h = 0; m = 0; s = 0; c = $urandom_range(0, 40);
            end else begin
                h = $urandom_range(0, 127); m = $urandom_range(0, 127);
                s = $urandom_range(0, 127); c = $urandom_range(0, 255);
            end
            step(ld, r, h, m, s, c);
            if (i == 1500) do_reset();
        end

        @(negedge clock);
        #1 check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Preset-and-count-down companion to the up-counting stopwatch.
- Loads an HH:MM:SS.cc value, decrements it at 100 Hz while run is high, and stops at zero with a held expired flag and a one-clock alarm pulse.
- Sits beside the stopwatch and drives the same seven-segment display path, with identical field widths and ranges.
- Fully synchronous to clock: the 100 Hz rate is a clock-enable tick, never a derived or gated clock.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 100, decrement rate; DIV = CLK_HZ/TICK_HZ clocks per tick (integer, >= 2).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- load  in  1  single-cycle or level strobe; captures the set_* inputs.
- run  in  1  level; 1 = count down, 0 = pause.
- set_hour  in  7  preset hours.
- set_minute  in  7  preset minutes.
- set_second  in  7  preset seconds.
- set_csec  in  8  preset centiseconds.
- hour  out  7  current hours, 0..23.
- minute  out  7  current minutes, 0..59.
- second  out  7  current seconds, 0..59.
- c_sec  out  8  current centiseconds, 0..99.
- running  out  1  high in state RUN.
- expired  out  1  high in state EXPIRED.
- alarm  out  1  one-clock pulse on the zero-reaching transition.

Behaviour:
- Reset (async): all time outputs 0, running=0, expired=0, alarm=0, state IDLE, divider count 0.
- Divider:
  - Counts 0..DIV-1 only in state RUN; holds its value in PAUSE, so tick phase is preserved across a pause.
  - Cleared on load and on reset.
  - Internal tick is high for one clock when the count == DIV-1 in RUN.
  - First tick comes DIV clocks after entering RUN from a cleared divider.
- Load clamping is applied at capture: hour>23→23, minute>59→59, second>59→59, csec>99→99.
- States:
  - IDLE: value held.
    - load → IDLE with the new value.
    - run=1 and value≠0 → RUN.
    - run=1 and value==0 → stay IDLE; no alarm and no expired.
  - RUN: decrement on each tick.
    - run=0 → PAUSE.
    - A tick while value == 00:00:00.01 → value becomes 0, alarm=1 for that clock, next state EXPIRED.
  - PAUSE: value and divider held; run=1 → RUN.
  - EXPIRED: value stays 0, expired=1, run ignored. Leaves only via load (→IDLE) or reset.
- Priority within one edge: reset > load > tick > run transitions.
  - Load in any state: capture the value, clear the divider, go to IDLE, drop expired.
  - If run=1 on the next clock with a nonzero value, go to RUN.
  - A load on the same edge as a tick discards the tick.
- Decrement (on tick, all fields updated on the same edge, zero latency from tick):
  - c_sec>0: c_sec-1.
  - Else c_sec=99 and borrow from seconds; second 0→59 borrows from minutes; minute 0→59 borrows from hours; hour-1.
  - The all-zero case never decrements; it is caught by the expiry rule, so there is no wrap below zero.
- Outputs are registered. running and expired are decoded from the state register. alarm is registered and high exactly one clock.
- run changing mid-tick-period affects only the divider hold; no partial tick is issued.

Decomposition:
- Shared package timer_pkg holds:
  - Constants CSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Field widths HMS_W=7, CSEC_W=8.
  - State enum {IDLE, RUN, PAUSE, EXPIRED}.
- The stopwatch adopts the same package constants.
- Sub-module tick_divider (parameters CLK_HZ, TICK_HZ; inputs clock, reset, enable, clear; output tick). It is reusable by the stopwatch in place of its toggled clock.

Test Plan:
Benches use CLK_HZ=1000, TICK_HZ=100, so DIV=10.
1. Reset asserted mid-count at 00:00:05.50 → all outputs 0 immediately (async), state IDLE; counting does not resume after release until load+run.
2. Load 00:00:01.05, run=1 → after 105 ticks (1050 clocks from RUN entry) value 0, alarm high exactly one clock, expired held, running=0; further run toggles leave the value 0.
3. Load 01:00:00.00, run → after 1 tick 00:59:59.99; load 00:01:00.00 → after 1 tick 00:00:59.99.
4. Load 00:00:00.50, run; drop run 3 clocks after the 2nd tick for 50 clocks → value holds 00:00:00.48. On resume, the next tick arrives 7 clocks later (phase preserved), giving 00:00:00.47.
5. Load 30:75:80.150 → outputs 23:59:59.99. Load all zeros with run=1 → stays IDLE, no alarm, expired=0.
6. Load 00:00:10.00 while RUN at 00:00:03.20, on the same edge as a tick → value 00:00:10.00, tick discarded, divider cleared; with run held, the next tick comes 10 clocks after RUN re-entry.
